ysyx_24080014_pc_gen: RTL and testbench

//  Parametrised fetch-PC generator; replaces the bare PC register at the front of the IFU.

---
 rtl/ysyx_24080014_pc_gen.sv | 105 ++++++++++
 tb/tb_ysyx_24080014_pc_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080014_pc_gen.sv
// Fetch-PC generator for the IFU front end: holds the fetch PC, issues one
// instruction-memory request at a time and applies trap/branch redirects.
module ysyx_24080014_pc_gen #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(32'h8000_0000),
  parameter int unsigned      STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_pc,
  input  logic            resp_valid,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     perf_redirects
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     perf_q, perf_d;

  logic            redir;
  logic [XLEN-1:0] tgt;

  // NOTE: every signal written here gets a default at the top of the block, so
  // no path through the case statement can leave one unassigned (no latch).
  always_comb begin
    redir       = trap_valid | redirect_valid;
    tgt         = trap_valid ? trap_pc : redirect_pc;
    tgt[1:0]    = 2'b00;

    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = 1'b0;
    out_pc_d    = out_pc_q;
    perf_d      = perf_q;
    req_valid   = 1'b0;

    case (state_q)
      S_REQ: begin
        req_valid = !stall && !redir;
        if (redir) begin
          pc_d = tgt;
        end else if (req_valid && req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          // A response arriving with the redirect belongs to the old path.
          pc_d    = tgt;
          state_d = resp_valid ? S_REQ : S_DROP;
        end else if (resp_valid) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          pc_d        = pc_q + XLEN'(STEP);
          state_d     = S_REQ;
        end
      end
      S_DROP: begin
        if (redir)      pc_d    = tgt;
        if (resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redir && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_VEC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      perf_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      perf_q      <= perf_d;
    end
  end

  assign req_pc         = pc_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign perf_redirects = perf_q;

endmodule

// File: tb/tb_ysyx_24080014_pc_gen.sv
// Bench for ysyx_24080014_pc_gen: directed scenarios plus random traffic, all
// compared against a transaction-level model of the fetch PC and memory.
module tb_ysyx_24080014_pc_gen;

  localparam logic [31:0] RVEC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
  logic [31:0] redirect_pc = '0, trap_pc = '0;
  logic        req_ready = 1'b0, resp_valid = 1'b0;
  logic        req_valid, out_valid;
  logic [31:0] req_pc, out_pc, perf_redirects;

  logic        rst2 = 1'b1, req_ready2 = 1'b0, resp_valid2 = 1'b0;
  logic        req_valid2, out_valid2;
  logic [31:0] req_pc2, out_pc2, perf2;

  always #5 clk = ~clk;

  ysyx_24080014_pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .out_valid(out_valid), .out_pc(out_pc),
    .perf_redirects(perf_redirects)
  );

  ysyx_24080014_pc_gen #(.RESET_VEC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .trap_valid(1'b0), .trap_pc(32'h0),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_pc(req_pc2),
    .resp_valid(resp_valid2), .out_valid(out_valid2), .out_pc(out_pc2),
    .perf_redirects(perf2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the fetch unit either has no request in flight, or has
  // one whose response is still wanted, or one whose response will be thrown away.
  logic [31:0] m_pc, m_out_pc, m_perf;
  logic        m_busy, m_stale, m_out_valid;
  // Memory model: one pending response with a countdown in cycles.
  logic        mem_pending;
  int          mem_cnt;
  int          lat_force = -1;

  task automatic model_reset();
    m_pc = RVEC; m_out_pc = '0; m_perf = '0;
    m_busy = 1'b0; m_stale = 1'b0; m_out_valid = 1'b0;
    mem_pending = 1'b0; mem_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic tv, input logic [31:0] tpc, input logic rdy);
    logic        redir, resp, exp_req;
    logic [31:0] tgt;
    redir = rv | tv;
    tgt   = tv ? tpc : rpc;
    tgt   = {tgt[31:2], 2'b00};
    resp  = mem_pending && (mem_cnt == 0);
    exp_req = !m_busy && !s && !redir;
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    trap_valid = tv; trap_pc = tpc; req_ready = rdy; resp_valid = resp;
    #1;
    check("req_valid", req_valid, exp_req);
    check("req_pc", req_pc, m_pc);
    check("out_valid", out_valid, m_out_valid);
    check("out_pc", out_pc, m_out_pc);
    check("perf", perf_redirects, m_perf);
    @(posedge clk);
    if (redir && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
    m_out_valid = 1'b0;
    if (!m_busy) begin
      if (redir) m_pc = tgt;
      else if (exp_req && rdy) begin m_busy = 1'b1; m_stale = 1'b0; end
    end else if (!m_stale) begin
      if (redir) begin
        m_pc = tgt;
        if (resp) m_busy = 1'b0; else m_stale = 1'b1;
      end else if (resp) begin
        m_out_valid = 1'b1; m_out_pc = m_pc; m_pc = m_pc + 4; m_busy = 1'b0;
      end
    end else begin
      if (redir) m_pc = tgt;
      if (resp) begin m_busy = 1'b0; m_stale = 1'b0; end
    end
    if (resp) mem_pending = 1'b0;
    else if (mem_pending) mem_cnt--;
    if (exp_req && rdy) begin
      mem_pending = 1'b1;
      mem_cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 2));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  logic [31:0] perf_before;

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state and first request.
    #1;
    check("t1_req_valid", req_valid, 1'b1);
    check("t1_req_pc", req_pc, 32'h8000_0000);
    check("t1_out_valid", out_valid, 1'b0);
    check("t1_perf", perf_redirects, 32'h0);
    @(negedge clk);

    // Sequential fetch with 1-cycle memory.
    lat_force = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      idle(1'b1);
      check("t2_out_valid", out_valid, 1'b1);
      check("t2_out_pc", out_pc, RVEC + 32'(4 * i));
    end
    idle(1'b0);
    check("t2_pulse", out_valid, 1'b0);

    // Redirect while waiting: stale response must be dropped.
    lat_force = 1;
    idle(1'b1);
    cycle(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    check("t3_no_out", out_valid, 1'b0);
    check("t3_req_pc", req_pc, 32'h8000_0100);
    idle(1'b0);
    check("t3_no_out2", out_valid, 1'b0);

    // Trap wins over simultaneous branch redirect.
    perf_before = perf_redirects;
    cycle(1'b0, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0200, 1'b1);
    check("t4_req_pc", req_pc, 32'h8000_0200);
    check("t4_perf", perf_redirects, perf_before + 1);

    // Stall holds the PC; redirect during stall is aligned.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check("t5_pc_stable", req_pc, 32'h8000_0200);
    end
    cycle(1'b1, 1'b1, 32'h8000_0042, 1'b0, 32'h0, 1'b1);
    check("t5_aligned", req_pc, 32'h8000_0040);

    // Random traffic with a mid-run reset.
    lat_force = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 15) == 0, $urandom, 1'($urandom_range(0, 1)));
    end

    // PC wraps modulo 2^32 from a top-of-space reset vector.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0; req_ready2 = 1'b1;
    #1;
    check("t6_req_valid", req_valid2, 1'b1);
    check("t6_req_pc", req_pc2, 32'hFFFF_FFFC);
    @(negedge clk);
    resp_valid2 = 1'b1; req_ready2 = 1'b0;
    #1;
    check("t6_wait", req_valid2, 1'b0);
    @(negedge clk);
    resp_valid2 = 1'b0;
    #1;
    check("t6_out_valid", out_valid2, 1'b1);
    check("t6_out_pc", out_pc2, 32'hFFFF_FFFC);
    check("t6_wrap_pc", req_pc2, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
